// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : systolic_pkg
// Brief    : Shared state encoding and sizing helpers for systolic_os_array.
// Revision : 1.0
// ============================================================================
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Full 2W-bit product plus headroom for K_MAX accumulations.
   function automatic int acc_width(input int w, input int k_max);
      return 2 * w + $clog2(k_max);
   endfunction

   function automatic int c_idx(input int r, input int c, input int cols);
      return r * cols + c;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sa_pe.sv
`default_nettype none
// ============================================================================
// Module   : sa_pe
// Brief    : Output-stationary PE: registered a/b/tag forwarding, MAC on tag.
// Revision : 1.0
// ============================================================================
module sa_pe
   import systolic_pkg::*;
#(
   parameter int W      = 8,
   parameter int ACC_W  = 20,
   parameter int SIGNED = 0
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_clr,
   input  logic [W-1:0]     i_a,
   input  logic [W-1:0]     i_b,
   input  logic             i_tag,
   output logic [W-1:0]     o_a,
   output logic [W-1:0]     o_b,
   output logic             o_tag,
   output logic [ACC_W-1:0] o_acc
);

   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic             r_tag;
   logic [ACC_W-1:0] r_acc;
   logic [ACC_W-1:0] w_a_ext;
   logic [ACC_W-1:0] w_b_ext;
   logic [ACC_W-1:0] w_prod;

   // Extending operands to ACC_W before multiplying yields the extended product directly.
   if (SIGNED != 0) begin : g_signed
      assign w_a_ext = ACC_W'($signed(i_a));
      assign w_b_ext = ACC_W'($signed(i_b));
   end else begin : g_unsigned
      assign w_a_ext = ACC_W'(i_a);
      assign w_b_ext = ACC_W'(i_b);
   end

   assign w_prod = w_a_ext * w_b_ext;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_tag <= 1'b0;
         r_acc <= '0;
      end else if (i_clr) begin
         r_a   <= '0;
         r_b   <= '0;
         r_tag <= 1'b0;
         r_acc <= '0;
      end else begin
         r_a   <= i_a;
         r_b   <= i_b;
         r_tag <= i_tag;
         if (i_tag) begin
            r_acc <= r_acc + w_prod;
         end
      end
   end

   assign o_a   = r_a;
   assign o_b   = r_b;
   assign o_tag = r_tag;
   assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/systolic_os_array.sv
`default_nettype none
// ============================================================================
// Module   : systolic_os_array
// Brief    : Parametrised output-stationary systolic matmul, internal skew,
//            bubbles, signed mode, K-overflow flag, abort and result backpressure.
// Revision : 1.0
// ============================================================================
module systolic_os_array
   import systolic_pkg::*;
#(
   parameter int  W      = 8,
   parameter int  ROWS   = 3,
   parameter int  COLS   = 3,
   parameter int  K_MAX  = 16,
   parameter int  SIGNED = 0,
   localparam int ACC_W  = acc_width(W, K_MAX)
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_valid,
   output logic                        o_ready,
   input  logic                        i_last,
   input  logic [W*ROWS-1:0]           i_A,
   input  logic [W*COLS-1:0]           i_B,
   input  logic                        i_abort,
   output logic                        o_valid,
   input  logic                        i_ready,
   output logic [ACC_W*ROWS*COLS-1:0]  o_C,
   output logic                        o_kovf,
   output logic                        o_busy
);

   localparam int                   c_cnt_w      = $clog2(K_MAX + 1);
   localparam int                   c_drain_w    = $clog2(ROWS + COLS);
   localparam logic [c_drain_w-1:0] c_drain_init = c_drain_w'(ROWS + COLS - 2);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 w_ready;
   logic                 w_accept;
   logic                 w_hs;
   logic                 w_clr;
   logic [c_cnt_w-1:0]   r_beats;
   logic                 r_kovf;
   logic [c_drain_w-1:0] r_drain_cnt;

   logic [W-1:0]     w_a   [ROWS][COLS+1];
   logic             w_t   [ROWS][COLS+1];
   logic [W-1:0]     w_b   [ROWS+1][COLS];
   logic [ACC_W-1:0] w_acc [ROWS][COLS];
   logic [ROWS*(W+1)+COLS*W-1:0] w_unused_edge;

   assign w_ready  = ((r_state == IDLE) || (r_state == RUN)) && !i_abort;
   assign w_accept = i_valid && w_ready;
   assign w_hs     = (r_state == DONE) && i_ready;
   assign w_clr    = i_abort || w_hs;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (i_last) w_state_nxt = DRAIN;
               else        w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (w_accept && i_last) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (r_drain_cnt == '0) w_state_nxt = DONE;
         end
         DONE: begin
            if (i_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
      if (i_abort) w_state_nxt = IDLE;
   end

   // DONE is entered on the edge PE(ROWS-1,COLS-1) takes its last product.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_drain_cnt <= '0;
      end else if (i_abort) begin
         r_drain_cnt <= '0;
      end else if (w_accept && i_last) begin
         r_drain_cnt <= c_drain_init;
      end else if ((r_state == DRAIN) && (r_drain_cnt != '0)) begin
         r_drain_cnt <= r_drain_cnt - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_beats <= '0;
         r_kovf  <= 1'b0;
      end else if (w_clr) begin
         r_beats <= '0;
         r_kovf  <= 1'b0;
      end else if (w_accept) begin
         if (r_beats >= c_cnt_w'(K_MAX)) r_kovf <= 1'b1;
         if (r_beats != {c_cnt_w{1'b1}}) r_beats <= r_beats + 1'b1;
      end
   end

   assign o_ready = w_ready;
   assign o_valid = (r_state == DONE);
   assign o_busy  = (r_state != IDLE);
   assign o_kovf  = r_kovf;

   // Row r of A and its tag see r+1 registers before PE(r,0), column c of B sees c+1.
   for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
      logic [W-1:0] r_a_dly [r+1];
      logic         r_t_dly [r+1];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int i = 0; i <= r; i++) begin
               r_a_dly[i] <= '0;
               r_t_dly[i] <= 1'b0;
            end
         end else if (i_abort) begin
            for (int i = 0; i <= r; i++) begin
               r_a_dly[i] <= '0;
               r_t_dly[i] <= 1'b0;
            end
         end else begin
            r_a_dly[0] <= i_A[r*W +: W];
            r_t_dly[0] <= w_accept;
            for (int i = 1; i <= r; i++) begin
               r_a_dly[i] <= r_a_dly[i-1];
               r_t_dly[i] <= r_t_dly[i-1];
            end
         end
      end

      assign w_a[r][0] = r_a_dly[r];
      assign w_t[r][0] = r_t_dly[r];
      assign w_unused_edge[r*(W+1) +: W+1] = {w_t[r][COLS], w_a[r][COLS]};
   end

   for (genvar c = 0; c < COLS; c++) begin : g_col_skew
      logic [W-1:0] r_b_dly [c+1];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            for (int i = 0; i <= c; i++) r_b_dly[i] <= '0;
         end else if (i_abort) begin
            for (int i = 0; i <= c; i++) r_b_dly[i] <= '0;
         end else begin
            r_b_dly[0] <= i_B[c*W +: W];
            for (int i = 1; i <= c; i++) r_b_dly[i] <= r_b_dly[i-1];
         end
      end

      assign w_b[0][c] = r_b_dly[c];
      assign w_unused_edge[ROWS*(W+1) + c*W +: W] = w_b[ROWS][c];
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
      for (genvar c = 0; c < COLS; c++) begin : g_pe_col
         sa_pe #(
            .W      (W),
            .ACC_W  (ACC_W),
            .SIGNED (SIGNED)
         ) u_pe (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clr   (w_clr),
            .i_a     (w_a[r][c]),
            .i_b     (w_b[r][c]),
            .i_tag   (w_t[r][c]),
            .o_a     (w_a[r][c+1]),
            .o_b     (w_b[r+1][c]),
            .o_tag   (w_t[r][c+1]),
            .o_acc   (w_acc[r][c])
         );

         assign o_C[c_idx(r, c, COLS)*ACC_W +: ACC_W] = w_acc[r][c];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_systolic_os_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_os_array
// Brief    : Directed self-checking bench for systolic_os_array (3x3 u/s, 2x5).
// Revision : 1.0
// ============================================================================
module tb_systolic_os_array;

   localparam int ACC = 20;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic v, last, abort, rdy;
   logic [23:0] a_bus, b_bus;

   logic rdy_u, val_u, kovf_u, busy_u;
   logic rdy_s, val_s, kovf_s, busy_s;
   logic [179:0] c_u, c_s;

   logic v2, last2, rdy2, val2, kovf2, busy2;
   logic [15:0]  a2;
   logic [39:0]  b2;
   logic [199:0] c2;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;
   int am [3][3];
   int em [3][3];
   int ba [32][3];
   int bb [32][3];
   int le;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   systolic_os_array #(.W(8), .ROWS(3), .COLS(3), .K_MAX(16), .SIGNED(0)) dut_u (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v), .o_ready(rdy_u), .i_last(last),
      .i_A(a_bus), .i_B(b_bus), .i_abort(abort), .o_valid(val_u), .i_ready(rdy),
      .o_C(c_u), .o_kovf(kovf_u), .o_busy(busy_u));

   systolic_os_array #(.W(8), .ROWS(3), .COLS(3), .K_MAX(16), .SIGNED(1)) dut_s (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v), .o_ready(rdy_s), .i_last(last),
      .i_A(a_bus), .i_B(b_bus), .i_abort(abort), .o_valid(val_s), .i_ready(rdy),
      .o_C(c_s), .o_kovf(kovf_s), .o_busy(busy_s));

   systolic_os_array #(.W(8), .ROWS(2), .COLS(5), .K_MAX(16), .SIGNED(0)) dut_25 (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(v2), .o_ready(rdy2), .i_last(last2),
      .i_A(a2), .i_B(b2), .i_abort(1'b0), .o_valid(val2), .i_ready(1'b1),
      .o_C(c2), .o_kovf(kovf2), .o_busy(busy2));

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [179:0] pack3(input int m [3][3]);
      logic [179:0] p;
      p = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            p[(r*3+c)*ACC +: ACC] = ACC'(m[r][c]);
      return p;
   endfunction

   task automatic load_identity();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 3; i++) begin
            ba[k][i] = am[i][k];
            bb[k][i] = (k == i) ? 1 : 0;
         end
   endtask

   task automatic fill_const(input int n, input int val);
      for (int k = 0; k < n; k++)
         for (int i = 0; i < 3; i++) begin
            ba[k][i] = val;
            bb[k][i] = val;
         end
   endtask

   // Called and returns at a negedge; le is the cycle count of the last acceptance edge.
   task automatic send(input int nb, input int gap, input bit with_last, output int le_o);
      for (int k = 0; k < nb; k++) begin
         for (int i = 0; i < 3; i++) begin
            a_bus[i*8 +: 8] = 8'(ba[k][i]);
            b_bus[i*8 +: 8] = 8'(bb[k][i]);
         end
         v    = 1'b1;
         last = with_last && (k == nb - 1);
         @(negedge clk);
         v    = 1'b0;
         last = 1'b0;
         if (k < nb - 1) repeat (gap) @(negedge clk);
      end
      le_o = cyc;
   endtask

   task automatic wait_result(input int le_i, input int exp_lat, input string tag);
      int n;
      n = 0;
      while (!val_u && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " valid seen"}, val_u, 1'b1);
      if (val_u) begin
         chk({tag, " latency"}, cyc - le_i, exp_lat);
         chk({tag, " signed valid"}, val_s, 1'b1);
      end
   endtask

   task automatic no_valid_for(input int n, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (val_u || val_s) seen++;
      end
      chk(tag, seen, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      v = 0; last = 0; abort = 0; rdy = 1; a_bus = '0; b_bus = '0;
      v2 = 0; last2 = 0; a2 = '0; b2 = '0;
      am = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
      repeat (2) @(negedge clk);

      chk("rst ready", {rdy_u, rdy_s}, 2'b11);
      chk("rst valid", {val_u, val_s}, 2'b00);
      chk("rst kovf", {kovf_u, kovf_s}, 2'b00);
      chk("rst busy", {busy_u, busy_s}, 2'b00);
      chk("rst C", c_u, '0);
      rst_n = 1'b1;
      @(negedge clk);

      // Identity, back-to-back beats
      load_identity();
      send(3, 0, 1'b1, le);
      wait_result(le, 5, "ident");
      chk("ident C", c_u, pack3(am));
      chk("ident C signed", c_s, pack3(am));
      chk("ident kovf", kovf_u, 1'b0);
      @(negedge clk);
      chk("ident back to idle", {busy_u, val_u}, 2'b00);

      // Same matrices with two bubbles between beats
      send(3, 2, 1'b1, le);
      wait_result(le, 5, "bubble");
      chk("bubble C", c_u, pack3(am));
      @(negedge clk);

      // K=1 outer product
      ba[0] = '{1, 2, 3};
      bb[0] = '{4, 5, 6};
      send(1, 0, 1'b1, le);
      wait_result(le, 5, "outer");
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) em[r][c] = (r + 1) * (c + 4);
      chk("outer C", c_u, pack3(em));
      chk("outer C22", c_u[8*ACC +: ACC], 18);
      @(negedge clk);

      // Signed vs unsigned interpretation of 0xFF
      ba[0] = '{255, 1, 0};
      bb[0] = '{2, 255, 0};
      send(1, 0, 1'b1, le);
      wait_result(le, 5, "sign");
      chk("sign u C00", c_u[0*ACC +: ACC], 510);
      chk("sign u C01", c_u[1*ACC +: ACC], 65025);
      chk("sign u C11", c_u[4*ACC +: ACC], 255);
      chk("sign s C00", c_s[0*ACC +: ACC], 20'hFFFFE);
      chk("sign s C01", c_s[1*ACC +: ACC], 1);
      chk("sign s C11", c_s[4*ACC +: ACC], 20'hFFFFF);
      @(negedge clk);

      // 2x5 configuration, K=1
      chk("2x5 ready", rdy2, 1'b1);
      v2 = 1; last2 = 1;
      a2 = {8'd2, 8'd1};
      b2 = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
      @(negedge clk);
      v2 = 0; last2 = 0;
      le = cyc;
      begin
         int n;
         n = 0;
         while (!val2 && n < 20) begin
            @(negedge clk);
            n++;
         end
      end
      chk("2x5 valid seen", val2, 1'b1);
      chk("2x5 latency", cyc - le, 6);
      chk("2x5 C00", c2[0*ACC +: ACC], 1);
      chk("2x5 C03", c2[3*ACC +: ACC], 4);
      chk("2x5 C12", c2[7*ACC +: ACC], 6);
      chk("2x5 C14", c2[9*ACC +: ACC], 10);
      @(negedge clk);
      chk("2x5 idle", {busy2, kovf2}, 2'b00);

      // -128 operands, 17 beats overflows K_MAX, 16 does not
      fill_const(17, 128);
      send(17, 0, 1'b1, le);
      wait_result(le, 5, "kovf17");
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) em[r][c] = 278528;
      chk("kovf17 C signed", c_s, pack3(em));
      chk("kovf17 C unsigned", c_u, pack3(em));
      chk("kovf17 flag", {kovf_s, kovf_u}, 2'b11);
      @(negedge clk);
      chk("kovf cleared by handshake", {kovf_s, kovf_u}, 2'b00);
      send(16, 0, 1'b1, le);
      wait_result(le, 5, "k16");
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) em[r][c] = 262144;
      chk("k16 C signed", c_s, pack3(em));
      chk("k16 flag", {kovf_s, kovf_u}, 2'b00);
      @(negedge clk);

      // Backpressure in DONE with beats offered
      load_identity();
      rdy = 0;
      send(3, 0, 1'b1, le);
      wait_result(le, 5, "bp");
      for (int i = 0; i < 10; i++) begin
         v = 1; last = 1; a_bus = 24'h555555; b_bus = 24'h555555;
         @(negedge clk);
         chk("bp valid held", val_u, 1'b1);
         chk("bp ready low", rdy_u, 1'b0);
         chk("bp C stable", c_u, pack3(am));
      end
      v = 0; last = 0; rdy = 1;
      @(negedge clk);
      chk("bp released idle", {busy_u, val_u, kovf_u}, 3'b000);
      send(3, 0, 1'b1, le);
      wait_result(le, 5, "bp next");
      chk("bp next C", c_u, pack3(am));
      @(negedge clk);

      // Abort during RUN; beat in the abort cycle is refused
      send(2, 0, 1'b0, le);
      chk("abort run busy", busy_u, 1'b1);
      abort = 1; v = 1;
      #1;
      chk("abort ready low", rdy_u, 1'b0);
      @(negedge clk);
      abort = 0; v = 0;
      chk("abort run idle", busy_u, 1'b0);

      // Abort during DRAIN
      send(3, 0, 1'b1, le);
      chk("drain busy", {busy_u, val_u}, 2'b10);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort drain idle", busy_u, 1'b0);
      no_valid_for(8, "abort drain no valid");

      // Reset mid-RUN
      send(2, 0, 1'b0, le);
      rst_n = 0;
      #1;
      chk("reset mid run", {busy_u, busy_s}, 2'b00);
      @(negedge clk);
      rst_n = 1;
      no_valid_for(8, "reset no valid");

      send(3, 0, 1'b1, le);
      wait_result(le, 5, "recover");
      chk("recover C", c_u, pack3(am));
      chk("recover kovf", kovf_u, 1'b0);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/systolic_os_array.md
Name: systolic_os_array

Overview:
- Parametrised output-stationary systolic matrix multiplier: successor to the fixed 3x3 array.
- Streams K beats, each beat carrying one column of A (ROWS elements) and one row of B (COLS elements).
- Input skewing is done internally, so callers present unskewed vectors.
- Accumulates C = A x B in place, drains, then presents C behind a valid/ready handshake.
- Adds what the 3x3 array lacks: bubbles, signed mode, K-overflow detection, abort and backpressure.

Parameters:
- W, 8, operand width in bits.
- ROWS, 3, PE rows (rows of A and C), >=1.
- COLS, 3, PE columns (columns of B and C), >=1.
- K_MAX, 16, maximum inner dimension guaranteed not to overflow.
- SIGNED, 0, 1 = operands and accumulators are two's complement; 0 = unsigned.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input beat accepted when i_valid & o_ready.
- i_last  in  1  qualifies the final beat of a matrix.
- i_A  in  W*ROWS  A column; element r at [r*W +: W].
- i_B  in  W*COLS  B row; element c at [c*W +: W].
- i_abort  in  1  synchronous discard of the current matrix.
- o_valid  out  1  result valid.
- i_ready  in  1  result consumer ready.
- o_C  out  ACC_W*ROWS*COLS  C(r,c) at [(r*COLS+c)*ACC_W +: ACC_W].
- o_kovf  out  1  sticky: more than K_MAX beats accepted for the current matrix.
- o_busy  out  1  state != IDLE.

Behaviour:
- ACC_W = 2*W + clog2(K_MAX). Product is a full 2W-bit value, sign- or zero-extended per SIGNED. Accumulation wraps modulo 2^ACC_W.
- Reset (async assert, sync release): state IDLE, all accumulators/skew/tag registers 0. o_ready=1, o_valid=0, o_kovf=0, o_busy=0, o_C=0.
- FSM states are IDLE, RUN, DRAIN, DONE. o_ready=1 in IDLE and RUN only.
- IDLE: an accepted beat moves to RUN, or directly to DRAIN if i_last.
- RUN: beats are accepted; an accepted beat with i_last moves to DRAIN.
- Skew and valid tags:
  - Row r of A is delayed r registers; column c of B is delayed c registers.
  - Every beat carries a valid tag. Non-accepted cycles inject tag 0 (bubble).
  - The tag travels with A horizontally.
  - PE(r,c) adds a*b only when its incoming tag is 1; bubbles leave it unchanged.
- Timing: a beat accepted at edge k is accumulated by PE(r,c) at edge k+1+r+c.
- DRAIN:
  - A counter loads ROWS+COLS-2 at DRAIN entry.
  - The FSM enters DONE, with o_valid=1, on the edge where PE(ROWS-1,COLS-1) performs its final accumulation.
  - That edge is exactly ROWS+COLS-1 edges after the i_last acceptance edge (5 for 3x3).
  - ROWS=COLS=1: DRAIN lasts one cycle.
- DONE:
  - o_C holds constant, o_valid=1, o_ready=0.
  - On o_valid & i_ready: accumulators, beat counter and o_kovf clear; next state is IDLE.
  - A new beat can be accepted the following cycle.
  - If i_ready is already high on DONE entry, the handshake completes in that first cycle.
- Beat counter (clog2(K_MAX+1) bits, saturating): o_kovf sets on the edge accepting beat K_MAX+1 and stays set until handshake, abort or reset. Results remain computed (wrapped) regardless.
- i_abort:
  - Takes priority over everything in any state: next state IDLE; accumulators, skew registers, tags, counter and o_kovf clear.
  - A beat presented in the abort cycle is not accepted (o_ready is forced to 0 that cycle).
- i_valid during DRAIN or DONE is ignored; no stall or state effect.
- Reset mid-operation discards the partial result with no output.

Decomposition:
- Package systolic_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - the acc_width(W,K_MAX) constant function;
  - C-index helper c_idx(r,c,COLS).
- Sub-module sa_pe:
  - Registered a/b/tag pass-through; accumulator with clear and signed/unsigned multiply.
  - Generated ROWS x COLS.
  - Skew delay lines are generate loops in the top.

Test Plan (W=8, ROWS=COLS=3, K_MAX=16 unless noted):
1. Identity: A=[[1,2,3],[4,5,6],[7,8,9]], B=I, 3 back-to-back beats -> C=A, o_valid exactly 5 cycles after the i_last edge, o_kovf=0.
2. Bubbles: same matrices with i_valid low 2 cycles between beats -> identical C, o_valid 5 cycles after i_last.
3. K=1 outer product: A=[1,2,3], B=[4,5,6] -> C(r,c)=(r+1)*(c+4), e.g. C(2,2)=18. Then 2x5 config (ROWS=2, COLS=5): o_valid 6 cycles after i_last.
4. Signed overflow: SIGNED=1, all operands -128, 17 beats -> every C=278528, o_kovf=1 until handshake; 16 beats -> 262144, o_kovf=0.
5. Backpressure: i_ready=0 for 10 cycles in DONE -> o_C stable, o_valid=1, o_ready=0, offered beats not consumed. i_ready=1 -> IDLE next cycle, next matrix unaffected.
6. Abort/reset: i_abort during RUN and again during DRAIN; i_rst_n low mid-RUN -> no o_valid. Next identity run yields the exact C from test 1.
